// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 default timing,
// derived totals and controller state encoding.
package vga_timing_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D
                             + H_SYNC_D + H_BP_D;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D
                             + V_SYNC_D + V_BP_D;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   function automatic logic in_span(
      input logic [9:0] v,
      input int         lo,
      input int         hi
   );
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable divider; counter parked at 0
// whenever run is low.
module pix_ce_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic pix_ce
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!run || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign pix_ce = run && (r_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel/line counters, syncs and
// a run/stop FSM that only ever stops on frame boundaries.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int DIV      = 4,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       pix_ce,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       frame_start,
   output logic       busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_LO = H_ACTIVE + H_FP;
   localparam int HS_HI = HS_LO + H_SYNC - 1;
   localparam int VS_LO = V_ACTIVE + V_FP;
   localparam int VS_HI = VS_LO + V_SYNC - 1;
   localparam logic [9:0] XMAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] YMAX = 10'(V_TOTAL - 1);
   localparam logic [9:0] XACT = 10'(H_ACTIVE);
   localparam logic [9:0] YACT = 10'(V_ACTIVE);

   state_t     r_state;
   state_t     w_next;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic [9:0] w_x;
   logic [9:0] w_y;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_video;
   logic       r_fs;
   logic       w_run;
   logic       w_ce;
   logic       w_eol;
   logic       w_eof;
   logic       w_on;

   assign w_run = (r_state != IDLE);

   pix_ce_gen #(
      .DIV(DIV)
   ) u_pix_ce_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (w_run),
      .pix_ce(w_ce)
   );

   assign w_eol = (r_x == XMAX);
   assign w_eof = w_ce && w_eol && (r_y == YMAX);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:     if (en) w_next = RUN;
         RUN:      if (!en) w_next = STOPPING;
         STOPPING: begin
            if (en) w_next = RUN;
            else if (w_eof) w_next = IDLE;
         end
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      w_x = r_x;
      w_y = r_y;
      if (w_ce) begin
         if (w_eol) begin
            w_x = '0;
            w_y = (r_y == YMAX) ? '0 : r_y + 10'd1;
         end else begin
            w_x = r_x + 10'd1;
         end
      end
      if (w_next == IDLE) begin
         w_x = '0;
         w_y = '0;
      end
   end

   assign w_on = (w_next != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // outputs decoded from next x/y so they line up with the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_video <= 1'b0;
         r_fs    <= 1'b0;
      end else begin
         r_x     <= w_x;
         r_y     <= w_y;
         r_hsync <= !(w_on && in_span(w_x, HS_LO, HS_HI));
         r_vsync <= !(w_on && in_span(w_y, VS_LO, VS_HI));
         r_video <= w_on && (w_x < XACT) && (w_y < YACT);
         r_fs    <= ((r_state == IDLE) && (w_next == RUN))
                 || (w_eof && (w_next != IDLE));
      end
   end

   assign pix_ce      = w_ce;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video;
   assign x           = r_x;
   assign y           = r_y;
   assign frame_start = r_fs;
   assign busy        = w_run;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunken raster
// (16x11 totals, DIV=3) so whole frames fit in a short run.
module tb_vga_timing_ctrl;

   localparam int DIV = 3;
   localparam int HT  = 16;
   localparam int VT  = 11;
   localparam int LINE  = HT * DIV;
   localparam int FRAME = HT * VT * DIV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       pix_ce;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] x;
   logic [9:0] y;
   logic       frame_start;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fs_cnt = 0;
   int t_fs = 0;
   int last_ce = -1;
   int gaps = 0;
   logic [9:0] wx = '0;
   logic [9:0] wy = '0;

   vga_timing_ctrl #(
      .DIV(DIV),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .pix_ce     (pix_ce),
      .hsync      (hsync),
      .vsync      (vsync),
      .video_on   (video_on),
      .x          (x),
      .y          (y),
      .frame_start(frame_start),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n || !busy) begin
         last_ce <= -1;
      end else if (pix_ce) begin
         if (last_ce >= 0 && (cyc - last_ce) != DIV)
            gaps <= gaps + 1;
         last_ce <= cyc;
      end
      if (rst_n && frame_start) begin
         fs_cnt <= fs_cnt + 1;
         t_fs   <= cyc;
      end
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int k);
      case (k)
         0:       return hsync;
         1:       return vsync;
         2:       return video_on;
         3:       return frame_start;
         4:       return busy;
         default: return (x == wx) && (y == wy);
      endcase
   endfunction

   task automatic wait_for(
      input  string tag,
      input  int    k,
      input  logic  v,
      output int    t
   );
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         hit = (sig(k) === v);
      end
      t = cyc;
      chk({tag, "_seen"}, 32'(hit), 1);
   endtask

   initial begin
      int t0, t1, t2, ta, tb, n, fs0;

      rst_n = 1'b0;
      en    = 1'b0;
      #22;
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_video", video_on, 0);
      chk("rst_pixce", pix_ce, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_busy", busy, 0);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_hsync", hsync, 1);
      chk("idle_video", video_on, 0);

      // start: frame_start on the en edge, x moves DIV clks later
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      chk("start_fs", frame_start, 1);
      chk("start_busy", busy, 1);
      chk("start_video", video_on, 1);
      n = 0;
      while (x == 10'd0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("first_ce_lat", n, DIV);
      chk("first_x", x, 1);

      wait_for("hs_fall", 0, 1'b0, ta);
      chk("hs_fall_t", ta - t0, 10 * DIV);
      chk("hs_fall_x", x, 10);
      wait_for("hs_rise", 0, 1'b1, tb);
      chk("hs_low_len", tb - ta, 3 * DIV);
      wait_for("hs_fall2", 0, 1'b0, tb);
      chk("line_period", tb - ta, LINE);

      wait_for("vs_fall", 1, 1'b0, ta);
      chk("vs_fall_t", ta - t0, 7 * LINE);
      chk("vs_fall_y", y, 7);
      chk("vs_fall_x", x, 0);
      wait_for("vs_rise", 1, 1'b1, tb);
      chk("vs_low_len", tb - ta, 2 * LINE);

      wait_for("fs1", 3, 1'b1, t1);
      chk("fs1_period", t1 - t0, FRAME);
      chk("fs1_xy", {x, y}, 0);
      wait_for("vo_fall", 2, 1'b0, ta);
      chk("video_len", ta - t1, 8 * DIV);
      wait_for("fs2", 3, 1'b1, t2);
      chk("fs2_period", t2 - t1, FRAME);

      // drop en mid-frame: the frame must finish
      wx = 10'd5;
      wy = 10'd3;
      wait_for("stop_pt", 5, 1'b1, ta);
      en = 1'b0;
      fs0 = fs_cnt;
      wait_for("stop_idle", 4, 1'b0, tb);
      chk("stop_at_eof", tb - t_fs, FRAME);
      chk("stop_xy", {x, y}, 0);
      chk("stop_hsync", hsync, 1);
      chk("stop_vsync", vsync, 1);
      chk("stop_video", video_on, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("stop_no_fs", fs_cnt, fs0);
      chk("stop_stay_idle", busy, 0);

      // stop request withdrawn mid-frame: no phase slip
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      ta = cyc;
      chk("restart_fs", frame_start, 1);
      wx = 10'd0;
      wy = 10'd2;
      wait_for("pause_pt", 5, 1'b1, tb);
      en = 1'b0;
      wy = 10'd4;
      wait_for("resume_pt", 5, 1'b1, tb);
      chk("resume_busy", busy, 1);
      en = 1'b1;
      wait_for("resume_fs", 3, 1'b1, tb);
      chk("resume_fs_t", tb - ta, FRAME);
      chk("ce_gaps", gaps, 0);

      // async reset inside hsync/vsync low
      wx = 10'd11;
      wy = 10'd8;
      wait_for("rst_pt", 5, 1'b1, ta);
      chk("pre_rst_hs", hsync, 0);
      chk("pre_rst_vs", vsync, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_x", x, 0);
      chk("arst_y", y, 0);
      chk("arst_hsync", hsync, 1);
      chk("arst_vsync", vsync, 1);
      chk("arst_video", video_on, 0);
      chk("arst_pixce", pix_ce, 0);
      chk("arst_fs", frame_start, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_fs", frame_start, 1);
      chk("post_xy", {x, y}, 0);
      chk("post_busy", busy, 1);
      repeat (DIV) @(posedge clk);
      #1;
      chk("post_x1", x, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
